// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 multiplier / divider producing HI/LO.
// Ports: i_clock, i_reset (async, active-high); i_start/i_op/i_a/i_b request (op 0=MULT, 1=DIV);
//        o_hi/o_lo results, o_busy while running, o_done and o_div_zero one-cycle completion pulses.
// Fixed 33-cycle latency for MULT/DIV, 1 cycle for divide-by-zero; i_start is ignored while busy.
module mult_div_unit (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DZ   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_dz_nxt;

  logic        r_busy;
  logic        r_done;
  logic        r_dz;

  logic [4:0]  r_cnt;
  logic        r_op;
  logic        r_neg_lo;   // sign of product (MULT) or quotient (DIV)
  logic        r_neg_hi;   // sign of remainder: follows the dividend
  logic [31:0] r_acc;      // upper product half / partial remainder
  logic [31:0] r_q;        // lower product half (multiplier shifts out) / dividend->quotient
  logic [31:0] r_d;        // |b|: multiplicand / divisor
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_madd;
  logic [32:0] w_dsh;
  logic        w_dge;
  logic [31:0] w_dsub;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Magnitudes; 0x80000000 maps to itself, which is correct as an unsigned value.
  assign w_abs_a = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_abs_b = i_b[31] ? (~i_b + 32'd1) : i_b;

  // Shift-add step: conditionally add multiplicand to the upper half, then shift
  // the 65-bit {carry, acc, q} right by one.
  assign w_madd = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_d} : 33'd0);

  // Restoring step: shift the next dividend bit into the remainder and subtract
  // if it fits. When it fits the difference is below 2^32, so a 32-bit subtract
  // is exact.
  assign w_dsh  = {r_acc, r_q[31]};
  assign w_dge  = (w_dsh >= {1'b0, r_d});
  assign w_dsub = w_dsh[31:0] - r_d;

  assign w_prod   = {r_acc, r_q};
  assign w_prod_s = r_neg_lo ? (~w_prod + 64'd1) : w_prod;
  assign w_quo    = r_neg_lo ? (~r_q + 32'd1) : r_q;
  assign w_rem    = r_neg_hi ? (~r_acc + 32'd1) : r_acc;

  // FSM state and status registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  // Next state and next status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_dz_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_op && (i_b == 32'd0)) ? S_DZ : S_RUN;
          w_busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      S_DZ: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
        w_dz_nxt    = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result write
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= 5'd0;
      r_op     <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_acc    <= 32'd0;
      r_q      <= 32'd0;
      r_d      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op     <= i_op;
            r_neg_lo <= i_a[31] ^ i_b[31];
            r_neg_hi <= i_a[31];
            r_acc    <= 32'd0;
            r_q      <= w_abs_a;
            r_d      <= w_abs_b;
            r_cnt    <= 5'd0;
          end
        end
        S_RUN: begin
          // 31 + 1 wraps to 0, leaving the counter cleared for the next op
          r_cnt <= r_cnt + 5'd1;
          if (r_op) begin
            r_acc <= w_dge ? w_dsub : w_dsh[31:0];
            r_q   <= {r_q[30:0], w_dge};
          end else begin
            r_acc <= w_madd[32:1];
            r_q   <= {w_madd[0], r_q[31:1]};
          end
        end
        S_FIX: begin
          if (r_op) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod_s[63:32];
            r_lo <= w_prod_s[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
// Driver pushes reference-model results per accepted request; a negedge monitor
// pops on o_done and also checks HI/LO hold, pulse exclusivity, latency and busy length.
module tb_mult_div_unit;

  logic        i_clock;
  logic        i_reset;
  logic        i_start;
  logic        i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;
  logic        o_div_zero;

  mult_div_unit dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div_zero (o_div_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    longint      due;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  int          bc = 0;            // busy cycles seen for the op in flight
  logic [31:0] m_hi = 32'd0;      // architectural HI/LO as the driver expects them
  logic [31:0] m_lo = 32'd0;
  logic [31:0] mon_hi = 32'd0;    // committed HI/LO the monitor expects to see held
  logic [31:0] mon_lo = 32'd0;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference model: plain signed arithmetic on 64-bit integers.
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.lat = 33;
    e.due = 0;
    if (!op) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = m_hi;
      e.lo = m_lo;
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle (or showing done).
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    e.due = cyc + 1 + longint'(e.lat);
    sbq.push_back(e);
    if (!e.dz) begin
      m_hi = e.hi;
      m_lo = e.lo;
    end
    i_start = 1'b1;
    i_op = op;
    i_a = a;
    i_b = b;
    @(negedge i_clock);
    i_start = 1'b0;
    i_a = $urandom;
    i_b = $urandom;
  endtask

  task automatic do_reset();
    @(posedge i_clock);
    #2 i_reset = 1'b1;
    #1;
    chk("rst_hi", {32'd0, o_hi}, 64'd0);
    chk("rst_lo", {32'd0, o_lo}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    chk("rst_div_zero", {63'd0, o_div_zero}, 64'd0);
    sbq.delete();
    mon_hi = 32'd0;
    mon_lo = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    bc = 0;
    #1 i_reset = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      @(negedge i_clock);
      n++;
    end
    if (o_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", n, cyc);
      do_reset();
    end
  endtask

  // junk_at > 0 pulses a divide-by-zero start at edge E<junk_at> while busy.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input int junk_at);
    issue(op, a, b);
    if (junk_at > 0) begin
      repeat (junk_at - 1) @(negedge i_clock);
      i_start = 1'b1;
      i_op = 1'b1;
      i_a = $urandom;
      i_b = 32'd0;
      @(negedge i_clock);
      i_start = 1'b0;
    end
    wait_done();
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 20));
      4: v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (!i_reset) begin
        chk("done_busy_excl", {63'd0, o_done & o_busy}, 64'd0);
        if (o_busy) bc++;
        if (o_done) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done with empty scoreboard (cycle %0d)", cyc);
          end else begin
            e = sbq.pop_front();
            chk("hi", {32'd0, o_hi}, {32'd0, e.hi});
            chk("lo", {32'd0, o_lo}, {32'd0, e.lo});
            chk("div_zero", {63'd0, o_div_zero}, {63'd0, e.dz});
            chk("latency", 64'(cyc), 64'(e.due));
            chk("busy_len", 64'(bc), 64'(e.lat));
            mon_hi = e.hi;
            mon_lo = e.lo;
          end
          bc = 0;
        end else begin
          chk("div_zero_idle", {63'd0, o_div_zero}, 64'd0);
          chk("hi_hold", {32'd0, o_hi}, {32'd0, mon_hi});
          chk("lo_hold", {32'd0, o_lo}, {32'd0, mon_lo});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    int          junk;
    i_reset = 1'b0;
    i_start = 1'b0;
    i_op = 1'b0;
    i_a = 32'd0;
    i_b = 32'd0;
    #1 i_reset = 1'b1;
    #2;
    chk("init_hi", {32'd0, o_hi}, 64'd0);
    chk("init_lo", {32'd0, o_lo}, 64'd0);
    chk("init_busy", {63'd0, o_busy}, 64'd0);
    chk("init_done", {63'd0, o_done}, 64'd0);
    chk("init_div_zero", {63'd0, o_div_zero}, 64'd0);
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);

    // 7 * -3
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    @(negedge i_clock);
    // most-negative squared, then DIV -7/2 started in the done cycle
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    // divide by zero keeps the previous HI/LO
    run_op(1'b1, 32'd100, 32'd0, 0);
    // overflow case
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    // start pulse while busy must be ignored
    run_op(1'b0, 32'd5, 32'd6, 10);
    // reset mid-divide, then a clean divide
    @(negedge i_clock);
    issue(1'b1, 32'd1000, 32'd7);
    repeat (14) @(negedge i_clock);
    do_reset();
    run_op(1'b1, 32'd9, 32'd4, 0);

    // randomized operations, mixing back-to-back and gapped issue
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom_range(0, 1));
      a = rnd_operand();
      b = rnd_operand();
      junk = 0;
      if (!(op && b == 32'd0) && $urandom_range(0, 3) == 0) junk = $urandom_range(1, 32);
      run_op(op, a, b, junk);
      repeat ($urandom_range(0, 2)) @(negedge i_clock);
    end

    repeat (5) @(negedge i_clock);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
